nsel_pipe_mux: RTL

NSEL_PIPE_MUX -- requirements
Module: nsel_pipe_mux

---
 rtl/nsel_pipe_mux.sv | 76 +++++++
 1 files changed

// File: rtl/nsel_pipe_mux.sv
`default_nettype none
// ============================================================================
// Module   : nsel_pipe_mux
// Brief    : One-stage registered N-way select with valid/ready handshake,
//            flush and out-of-range select flag. Optional macro
//            NSEL_PIPE_MUX_ERR_STICKY_EN makes sel_err sticky until rst.
// Revision : 1.0 - initial release
// ============================================================================
module nsel_pipe_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic                     sel_err
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  logic             capture;

  // sel_hit doubles as the in-range test, so no constant compare is needed
  // when NUM_SRC fills the whole select space.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = src_data[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= sel_hit ? sel_data : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else begin
`ifdef NSEL_PIPE_MUX_ERR_STICKY_EN
      if (capture && !sel_hit) begin
        sel_err <= 1'b1;
      end
`else
      sel_err <= capture && !sel_hit;
`endif
    end
  end

endmodule
`default_nettype wire
